// File: rtl/decoder.sv
// Three-digit BCD to 7-segment decoder with registered outputs (bit0=a .. bit6=g).
// Optional macro DECODER_LEADING_ZERO_BLANK_EN blanks the minutes digit when it is zero.
module decoder #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_one,
  input  logic [3:0] sec_two,
  input  logic [3:0] min,
  output logic [6:0] sec_one_segs,
  output logic [6:0] sec_two_segs,
  output logic [6:0] min_segs
);

  // Polarity is applied last, so the blank pattern flips along with the digits.
  localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] BLANK    = 7'h00 ^ POL_MASK;

  logic [6:0] sec_one_d, sec_one_q;
  logic [6:0] sec_two_d, sec_two_q;
  logic [6:0] min_d, min_q;
  logic [6:0] min_raw;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  always_comb begin
    sec_one_d = bcd_to_seg(sec_one) ^ POL_MASK;
    sec_two_d = bcd_to_seg(sec_two) ^ POL_MASK;
    min_raw   = bcd_to_seg(min);
`ifdef DECODER_LEADING_ZERO_BLANK_EN
    if (min == 4'd0) min_raw = 7'h00;
`else
    min_raw   = bcd_to_seg(min);
`endif
    min_d     = min_raw ^ POL_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_one_q <= BLANK;
      sec_two_q <= BLANK;
      min_q     <= BLANK;
    end else begin
      sec_one_q <= sec_one_d;
      sec_two_q <= sec_two_d;
      min_q     <= min_d;
    end
  end

  assign sec_one_segs = sec_one_q;
  assign sec_two_segs = sec_two_q;
  assign min_segs     = min_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed cases plus random stream against a table model.
// Instantiates an active-high and an active-low copy driven by the same inputs.
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sec_one = 4'd0, sec_two = 4'd0, min = 4'd0;
  logic [6:0] s1_segs, s2_segs, m_segs;
  logic [6:0] s1_al, s2_al, m_al;

  int vectors = 0;
  int miscompares = 0;

  logic [20:0] exp_prev;

  localparam logic [6:0] DIGIT_TBL [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  decoder #(.ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .sec_one(sec_one), .sec_two(sec_two), .min(min),
    .sec_one_segs(s1_segs), .sec_two_segs(s2_segs), .min_segs(m_segs));

  decoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .sec_one(sec_one), .sec_two(sec_two), .min(min),
    .sec_one_segs(s1_al), .sec_two_segs(s2_al), .min_segs(m_al));

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    if (code > 4'd9) return 7'h40;
    return DIGIT_TBL[code];
  endfunction

  // Expected {sec_one_segs, sec_two_segs, min_segs} for the active-high build.
  function automatic logic [20:0] model(input logic [3:0] s1, input logic [3:0] s2,
                                        input logic [3:0] m);
    logic [6:0] mseg;
    mseg = seg_of(m);
`ifdef DECODER_LEADING_ZERO_BLANK_EN
    if (m == 4'd0) mseg = 7'h00;
`endif
    return {seg_of(s1), seg_of(s2), mseg};
  endfunction

  task automatic step(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] m);
    @(negedge clk);
    sec_one = s1; sec_two = s2; min = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(4'd8, 4'd8, 4'd8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({s1_segs, s2_segs, m_segs} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", {s1_segs, s2_segs, m_segs}, 21'h0);
    end
    @(posedge clk); #1;
    vectors++;
    if ({s1_segs, s2_segs, m_segs} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_held got=%h want=%h", {s1_segs, s2_segs, m_segs}, 21'h0);
    end
    @(negedge clk);
    sec_one = 4'd4; sec_two = 4'd5; min = 4'd6;
    rst = 1'b0;
    #1;
    vectors++;
    if ({s1_segs, s2_segs, m_segs} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_release_early got=%h want=%h", {s1_segs, s2_segs, m_segs}, 21'h0);
    end
    @(posedge clk); #1;
    vectors++;
    if ({s1_segs, s2_segs, m_segs} !== model(4'd4, 4'd5, 4'd6)) begin
      miscompares++;
      $display("FAIL reset_first_load got=%h want=%h", {s1_segs, s2_segs, m_segs},
               model(4'd4, 4'd5, 4'd6));
    end
  endtask

  task automatic test_basic;
    step(4'd0, 4'd1, 4'd2);
    vectors++;
    if ({s1_segs, s2_segs, m_segs} !== {7'h3F, 7'h06, 7'h5B}) begin
      miscompares++;
      $display("FAIL basic_012 got=%h want=%h", {s1_segs, s2_segs, m_segs}, {7'h3F, 7'h06, 7'h5B});
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ins  [3][3];
    logic [20:0] want [3];
    ins[0] = '{4'd1, 4'd2, 4'd3}; want[0] = {7'h06, 7'h5B, 7'h4F};
    ins[1] = '{4'd9, 4'd9, 4'd9}; want[1] = {7'h6F, 7'h6F, 7'h6F};
    ins[2] = '{4'd7, 4'd8, 4'd2}; want[2] = {7'h07, 7'h7F, 7'h5B};
    for (int i = 0; i < 3; i++) begin
      step(ins[i][0], ins[i][1], ins[i][2]);
      vectors++;
      if ({s1_segs, s2_segs, m_segs} !== want[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, {s1_segs, s2_segs, m_segs}, want[i]);
      end
    end
  endtask

  task automatic test_sweep;
    for (int c = 0; c < 16; c++) begin
      step(4'(c), 4'(15 - c), 4'(c));
      vectors++;
      if ({s1_segs, s2_segs, m_segs} !== model(4'(c), 4'(15 - c), 4'(c))) begin
        miscompares++;
        $display("FAIL sweep code=%0d got=%h want=%h", c, {s1_segs, s2_segs, m_segs},
                 model(4'(c), 4'(15 - c), 4'(c)));
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [6:0] want_min;
`ifdef DECODER_LEADING_ZERO_BLANK_EN
    want_min = 7'h00;
`else
    want_min = 7'h3F;
`endif
    step(4'd0, 4'd0, 4'd0);
    vectors++;
    if ({s1_segs, s2_segs, m_segs} !== {7'h3F, 7'h3F, want_min}) begin
      miscompares++;
      $display("FAIL leading_zero got=%h want=%h", {s1_segs, s2_segs, m_segs},
               {7'h3F, 7'h3F, want_min});
    end
    step(4'd0, 4'd0, 4'd12);
    vectors++;
    if (m_segs !== 7'h40) begin
      miscompares++;
      $display("FAIL min_invalid got=%h want=%h", m_segs, 7'h40);
    end
  endtask

  task automatic test_random;
    logic [3:0]  r1, r2, rm;
    logic [20:0] want;
    step(4'd3, 4'd3, 4'd3);
    exp_prev = model(4'd3, 4'd3, 4'd3);
    for (int i = 0; i < 200; i++) begin
      r1 = 4'($urandom_range(0, 15));
      r2 = 4'($urandom_range(0, 15));
      rm = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      want = model(r1, r2, rm);
      @(negedge clk);
      sec_one = r1; sec_two = r2; min = rm;
      #1;
      vectors++;
      if ({s1_segs, s2_segs, m_segs} !== exp_prev) begin
        miscompares++;
        $display("FAIL rand_hold[%0d] got=%h want=%h", i, {s1_segs, s2_segs, m_segs}, exp_prev);
      end
      @(posedge clk); #1;
      vectors++;
      if ({s1_segs, s2_segs, m_segs} !== want) begin
        miscompares++;
        $display("FAIL rand_decode[%0d] in=%0d,%0d,%0d got=%h want=%h", i, r1, r2, rm,
                 {s1_segs, s2_segs, m_segs}, want);
      end
      vectors++;
      if ({s1_al, s2_al, m_al} !== ~want) begin
        miscompares++;
        $display("FAIL rand_active_low[%0d] got=%h want=%h", i, {s1_al, s2_al, m_al}, ~want);
      end
      exp_prev = want;
    end
  endtask

  task automatic test_active_low;
    step(4'd8, 4'd8, 4'd8);
    vectors++;
    if ({s1_al, s2_al, m_al} !== 21'h0) begin
      miscompares++;
      $display("FAIL active_low_888 got=%h want=%h", {s1_al, s2_al, m_al}, 21'h0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({s1_al, s2_al, m_al} !== {7'h7F, 7'h7F, 7'h7F}) begin
      miscompares++;
      $display("FAIL active_low_reset got=%h want=%h", {s1_al, s2_al, m_al}, {7'h7F, 7'h7F, 7'h7F});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_sweep;
    test_leading_zero;
    test_random;
    test_active_low;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter ACTIVE_LOW, default 0: when 1, every segment output bit is inverted after decoding and after the reset/blank value is applied.
REQ-002 clk  input  1  single clock; all outputs registered on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sec_one  input  4  BCD units-of-seconds digit.
REQ-005 sec_two  input  4  BCD tens-of-seconds digit.
REQ-006 min  input  4  BCD minutes digit.
REQ-007 sec_one_segs  output  7  segment pattern for sec_one.
REQ-008 sec_two_segs  output  7  segment pattern for sec_two.
REQ-009 min_segs  output  7  segment pattern for min.

Function
REQ-010 Each digit SHALL be decoded independently by an identical BCD-to-7-segment function.
REQ-011 Segment bit mapping SHALL be bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; with ACTIVE_LOW=0, 1 means segment lit.
REQ-012 Codes SHALL decode as follows: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F (ACTIVE_LOW=0 values).
REQ-013 Invalid codes 10-15 SHALL decode to a dash, 0x40 (segment g only).
REQ-014 Outputs SHALL be registered: a value applied before rising edge N appears on the outputs after edge N (1-cycle latency), and outputs SHALL be held stable between edges.
REQ-015 Inputs changing on every cycle SHALL produce a new decoded value each cycle with no loss and no reordering.
REQ-016 The three outputs SHALL update on the same edge; no digit may lag another.

Reset
REQ-017 While rst=1, all three outputs SHALL be the blank pattern (0x00 when ACTIVE_LOW=0, 0x7F when ACTIVE_LOW=1), asynchronously and immediately.
REQ-018 Reset asserted mid-operation SHALL override any pending decode; after rst falls, the first rising edge SHALL load the decode of the current inputs.

Configuration
REQ-019 Macro DECODER_LEADING_ZERO_BLANK_EN: when defined, min_segs SHALL show blank (0x00 when ACTIVE_LOW=0) whenever min==0; sec_two and sec_one are never blanked.
REQ-020 When the macro is not defined, min==0 SHALL display 0x3F like any other digit.
REQ-021 An invalid min code (10-15) SHALL show the dash regardless of the macro.

Verification
REQ-022 Reset: assert rst with any inputs -> all outputs 0x00 without waiting for a clock edge.
REQ-023 sec_one=0, sec_two=1, min=2, one clock -> sec_one_segs=0x3F, sec_two_segs=0x06, min_segs=0x5B.
REQ-024 Apply 1,2,3 then 9,9,9 then 7,8,2 on consecutive cycles -> outputs (0x06,0x5B,0x4F), then (0x6F,0x6F,0x6F), then (0x07,0x7F,0x5B), each one cycle after its input.
REQ-025 Sweep each input over 0-15 -> REQ-012 table for 0-9 and 0x40 for 10-15 on all three outputs.
REQ-026 sec_one=0, sec_two=0, min=0 -> min_segs=0x00 with DECODER_LEADING_ZERO_BLANK_EN defined and 0x3F without it; sec_one_segs and sec_two_segs =0x3F in both builds.
REQ-027 ACTIVE_LOW=1 with inputs 8,8,8 -> all outputs 0x00; with rst=1 -> all outputs 0x7F.
